// File: rtl/shift_register_piso_tx_pkg.sv
// Shared types, constants and elaboration helpers for the PISO transmitter.
package shift_register_piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_register_piso_tx_hold.sv
// One-word holding buffer that parks a word accepted while a frame is in flight.
module piso_hold_reg
    import shift_register_piso_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             ready
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (wr) begin
            data <= wr_data;
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

    assign ready = ~full;

endmodule

// File: rtl/shift_register_piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, MSB-first serial
// output with frame/done markers and an optional idle gap between frames.
module shift_register_piso_tx
    import shift_register_piso_tx_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic [WIDTH-1:0] PI,
    input  logic             LOAD,
    output logic             READY,
    output logic             SO,
    output logic             SO_VALID,
    output logic             FRAME,
    output logic             DONE,
    output logic             BUSY
);

    localparam int            BW       = clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             gap_done;
    logic             start;
    logic             from_hold;
    logic             hold_wr;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    assign accept   = LOAD & READY;
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
    // A word that starts a frame on its own accept edge never touches the hold buffer.
    assign hold_wr  = accept & ~start;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (C),
        .rst     (CLR),
        .wr      (hold_wr),
        .wr_data (PI),
        .rd      (start & from_hold),
        .data    (hold_data),
        .full    (hold_full),
        .ready   (READY)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                shreg   <= from_hold ? hold_data : PI;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        from_hold  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (GAP_CYCLES != 0) begin
                        state_next = GAP;
                    end else if (hold_full) begin
                        start      = 1'b1;
                        from_hold  = 1'b1;
                    end else if (accept) begin
                        start      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (hold_full) begin
                        start      = 1'b1;
                        from_hold  = 1'b1;
                        state_next = SHIFT;
                    end else if (accept) begin
                        start      = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            localparam int GW = clog2(GAP_CYCLES + 1);
            logic [GW-1:0] gap_cnt;

            // Down-counter loaded on the end-of-frame edge; GAP is left when it reads zero.
            always_ff @(posedge C or posedge CLR) begin
                if (CLR) begin
                    gap_cnt <= '0;
                end else if (last_bit) begin
                    gap_cnt <= GW'(GAP_CYCLES - 1);
                end else if ((state == GAP) && (gap_cnt != '0)) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end

            assign gap_done = (gap_cnt == '0);
        end else begin : g_no_gap
            assign gap_done = 1'b1;
        end
    endgenerate

    assign SO_VALID = (state == SHIFT);
    assign SO       = SO_VALID & shreg[WIDTH-1];
    assign FRAME    = SO_VALID && (bit_cnt == '0);
    assign DONE     = last_bit;
    assign BUSY     = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Self-checking bench: three transmitter configurations against a frame-timeline model.
module tb_shift_register_piso_tx;

    logic       c   = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pi  = 8'd0;
    logic       load = 1'b0;
    int         sel = 0;

    logic ld8, ldg, ld4;
    logic rdy8, so8, sv8, fr8, dn8, bs8;
    logic rdyg, sog, svg, frg, dng, bsg;
    logic rdy4, so4, sv4, fr4, dn4, bs4;
    logic [5:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every accepted word gets an accept edge and a start edge; all outputs follow.
    int         cur_w, cur_g, e;
    int         acc_q[$];
    int         start_q[$];
    logic [7:0] word_q[$];
    logic       ready_m;
    logic [7:0] sipo;

    logic [5:0] got, want;
    logic       po_chk;
    logic [7:0] po_got, po_want;

    always #5 c = ~c;

    assign ld8 = load && (sel == 0);
    assign ldg = load && (sel == 1);
    assign ld4 = load && (sel == 2);

    shift_register_piso_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut8 (
        .C(c), .CLR(clr), .PI(pi), .LOAD(ld8), .READY(rdy8), .SO(so8),
        .SO_VALID(sv8), .FRAME(fr8), .DONE(dn8), .BUSY(bs8));

    shift_register_piso_tx #(.WIDTH(8), .GAP_CYCLES(2)) dutg (
        .C(c), .CLR(clr), .PI(pi), .LOAD(ldg), .READY(rdyg), .SO(sog),
        .SO_VALID(svg), .FRAME(frg), .DONE(dng), .BUSY(bsg));

    shift_register_piso_tx #(.WIDTH(4), .GAP_CYCLES(0)) dut4 (
        .C(c), .CLR(clr), .PI(pi[3:0]), .LOAD(ld4), .READY(rdy4), .SO(so4),
        .SO_VALID(sv4), .FRAME(fr4), .DONE(dn4), .BUSY(bs4));

    // Observation vector order: {SO, SO_VALID, FRAME, DONE, BUSY, READY}
    always_comb begin
        obs = '0;
        case (sel)
            0:       obs = {so8, sv8, fr8, dn8, bs8, rdy8};
            1:       obs = {sog, svg, frg, dng, bsg, rdyg};
            default: obs = {so4, sv4, fr4, dn4, bs4, rdy4};
        endcase
    end

    task automatic model_clear();
        acc_q.delete();
        start_q.delete();
        word_q.delete();
        e       = 0;
        ready_m = 1'b1;
        sipo    = '0;
    endtask

    task automatic do_clear(input int s);
        sel   = s;
        cur_w = (s == 2) ? 4 : 8;
        cur_g = (s == 1) ? 2 : 0;
        @(negedge c);
        clr  = 1'b1;
        load = 1'b0;
        @(negedge c);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic tick(input logic ld, input logic [7:0] d);
        logic       so_pre, hold;
        logic [7:0] mask;
        int         st, k;
        mask   = 8'((1 << cur_w) - 1);
        load   = ld;
        pi     = d;
        so_pre = obs[5];
        @(posedge c);
        if (ld && ready_m) begin
            st = e;
            if (start_q.size() > 0 && start_q[$] + cur_w + cur_g > st)
                st = start_q[$] + cur_w + cur_g;
            acc_q.push_back(e);
            start_q.push_back(st);
            word_q.push_back(d & mask);
        end
        sipo = ((sipo << 1) | {7'd0, so_pre}) & mask;
        #1;
        want    = '0;
        hold    = 1'b0;
        po_chk  = 1'b0;
        po_want = '0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (e >= start_q[i] && e < start_q[i] + cur_w) begin
                k       = e - start_q[i];
                want[5] = word_q[i][cur_w-1-k];
                want[4] = 1'b1;
                want[3] = (k == 0);
                want[2] = (k == cur_w - 1);
            end
            if (acc_q[i] <= e && e < start_q[i] + cur_w + cur_g) want[1] = 1'b1;
            if (acc_q[i] <= e && e < start_q[i]) hold = 1'b1;
            if (e == start_q[i] + cur_w) begin
                po_chk  = 1'b1;
                po_want = word_q[i];
            end
        end
        want[0] = ~hold;
        ready_m = ~hold;
        got     = obs;
        po_got  = sipo;
        e++;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_tests++;
            if (obs !== 6'b000001) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %b want 000001", s, obs);
            end
        end
        @(negedge c);
        clr = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0] so_bits;
        do_clear(0);
        so_bits = '0;
        for (int t = 0; t < 12; t++) begin
            tick(t == 0, 8'hA5);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_frame edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL single_frame_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
            if (t < 8) so_bits = {so_bits[6:0], got[5]};
            if (t == 8) begin
                n_tests++;
                if (got[4] !== 1'b0 || po_got !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL single_frame_end: valid %b po %h want valid 0 po a5", got[4], po_got);
                end
            end
        end
        n_tests++;
        if (so_bits !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_frame_bits: got %h want a5", so_bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] rdy_hist;
        int         valid_cnt;
        do_clear(0);
        rdy_hist  = '0;
        valid_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick(t == 0 || t == 2, (t == 0) ? 8'h3C : 8'hC3);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL back_to_back_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
            if (t < 9) rdy_hist = {rdy_hist[7:0], got[0]};
            if (t < 16) valid_cnt += int'(got[4]);
            if (t == 8 || t == 15) begin
                n_tests++;
                if (got[3:2] !== ((t == 8) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL back_to_back_marks edge %0d: got frame/done %b", t, got[3:2]);
                end
            end
        end
        n_tests++;
        if (rdy_hist !== 9'b110000001 || valid_cnt != 16) begin
            n_fail++;
            $display("FAIL back_to_back_ready: got ready %b valid %0d want 110000001 16", rdy_hist, valid_cnt);
        end
    endtask

    task automatic test_gap();
        do_clear(1);
        for (int t = 0; t < 24; t++) begin
            tick(t < 2, (t == 0) ? 8'h96 : 8'h5B);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL gap edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL gap_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
            if (t >= 7 && t <= 10) begin
                n_tests++;
                if (got[4:3] !== ((t == 7) ? 2'b10 : (t == 10) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL gap_window edge %0d: got valid/frame %b", t, got[4:3]);
                end
            end
        end
    endtask

    task automatic test_clear_mid_frame();
        logic [7:0] w;
        do_clear(0);
        for (int t = 0; t < 4; t++) begin
            tick(t < 2, (t == 0) ? 8'hF0 : 8'h0F);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL clear_pre edge %0d: got %b want %b", t, got, want);
            end
        end
        #2;
        clr = 1'b1;
        #1;
        n_tests++;
        if (obs !== 6'b000001) begin
            n_fail++;
            $display("FAIL clear_async: got %b want 000001", obs);
        end
        @(negedge c);
        clr = 1'b0;
        model_clear();
        w = 8'($urandom);
        for (int t = 0; t < 20; t++) begin
            tick(t == 1, w);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL clear_post edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL clear_post_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
        end
    endtask

    task automatic test_load_held();
        do_clear(0);
        for (int t = 0; t < 44; t++) begin
            tick(t < 30, 8'($urandom));
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_held edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL load_held_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
        end
    endtask

    task automatic test_width4();
        logic [3:0] so_bits;
        logic [7:0] w;
        do_clear(2);
        so_bits = '0;
        w = 8'($urandom);
        for (int t = 0; t < 12; t++) begin
            tick(t == 0 || t == 4, (t == 0) ? 8'h09 : w);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL width4 edge %0d: got %b want %b", t, got, want);
            end
            if (po_chk) begin
                n_tests++;
                if (po_got !== po_want) begin
                    n_fail++;
                    $display("FAIL width4_po edge %0d: got %h want %h", t, po_got, po_want);
                end
            end
            if (t < 4) so_bits = {so_bits[2:0], got[5]};
            if (t == 3 || t == 4) begin
                n_tests++;
                if (got[4:2] !== ((t == 3) ? 3'b101 : 3'b110)) begin
                    n_fail++;
                    $display("FAIL width4_marks edge %0d: got valid/frame/done %b", t, got[4:2]);
                end
            end
        end
        n_tests++;
        if (so_bits !== 4'b1001) begin
            n_fail++;
            $display("FAIL width4_bits: got %b want 1001", so_bits);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            do_clear(s);
            for (int t = 0; t < 90; t++) begin
                tick(t < 70 && $urandom_range(0, 2) == 0, 8'($urandom));
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL random dut%0d edge %0d: got %b want %b", s, t, got, want);
                end
                if (po_chk) begin
                    n_tests++;
                    if (po_got !== po_want) begin
                        n_fail++;
                        $display("FAIL random_po dut%0d edge %0d: got %h want %h", s, t, po_got, po_want);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_clear_mid_frame();
        test_load_held();
        test_width4();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
